// File: rtl/ksa_pkg.sv
// Shared types and helpers for the Kogge-Stone adder result path.
// The result record is what travels through the skid buffer.
package ksa_pkg;

    localparam int unsigned KSA_WIDTH = 32;

    typedef struct packed {
        logic [KSA_WIDTH-1:0] sum;
        logic                 cout;
        logic                 zero;
        logic                 neg;
        logic                 ovf;
    } ksa_result_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
    } ksa_flags_t;

    localparam int unsigned KSA_RESULT_W = $bits(ksa_result_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Signed overflow: both operands share a sign the sum does not.
    function automatic ksa_flags_t ksa_flags(input logic                 a_msb,
                                             input logic                 b_msb,
                                             input logic [KSA_WIDTH-1:0] sum);
        ksa_flags_t f;
        f.zero = ~|sum;
        f.neg  = sum[KSA_WIDTH-1];
        f.ovf  = (a_msb == b_msb) && (sum[KSA_WIDTH-1] != a_msb);
        return f;
    endfunction

endpackage

// File: rtl/ksa_skid_buf.sv
// Generic 2-entry valid/ready buffer; the head register drives the outputs
// directly, and in_ready depends only on registered occupancy.
module ksa_skid_buf
    import ksa_pkg::*;
#(
    parameter int unsigned DATA_W = KSA_RESULT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    occ_e              occ_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              push;
    logic              pop;

    assign in_ready_o  = (occ_q != OCC_FULL);
    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign out_data_o  = head_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // When draining to empty the head is left untouched so outputs hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= in_data_i;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_q <= in_data_i;
                    end else if (push) begin
                        tail_q <= in_data_i;
                        occ_q  <= OCC_FULL;
                    end else if (pop) begin
                        occ_q  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= OCC_ONE;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ksa_result_stage.sv
// Registered result stage after the 32-bit Kogge-Stone adder: flag
// generation, skid buffering and debug counters.
module ksa_result_stage
    import ksa_pkg::*;
#(
    parameter int unsigned WIDTH = KSA_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ksa_flags_t       flags;
    ksa_result_t      in_rec;
    ksa_result_t      head;
    logic             push;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    assign flags       = ksa_flags(a_msb, b_msb, sum);
    assign in_rec.sum  = sum;
    assign in_rec.cout = cout;
    assign in_rec.zero = flags.zero;
    assign in_rec.neg  = flags.neg;
    assign in_rec.ovf  = flags.ovf;
    assign push        = in_valid & in_ready;

    ksa_skid_buf #(
        .DATA_W (KSA_RESULT_W)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_rec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head)
    );

    assign out_sum  = head.sum;
    assign out_cout = head.cout;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;
    assign out_ovf  = head.ovf;

    // Result count wraps; overflow count sticks at all-ones.
    always_comb begin
        res_cnt_d = res_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push) begin
            res_cnt_d = res_cnt_q + CNT_ONE;
            if (flags.ovf && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign res_count = res_cnt_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: doc/ksa_result_stage.md
Name: ksa_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit Kogge-Stone adder.
- Captures the adder's combinational sum/cout together with the operand sign bits.
- Derives status flags: zero, negative, carry, signed overflow.
- Presents results through a 2-entry valid/ready skid buffer, so the combinational adder path ends at a flop and downstream back-pressure never drops a result.
- Keeps a wrapping result counter and a saturating overflow counter for debug/perf.

Parameters:
WIDTH, 32, datapath width; must match the adder
CNT_W, 16, width of the result and overflow counters

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream operands valid, so adder outputs are valid this cycle
in_ready  output  1  stage can accept this cycle
a_msb  input  1  operand a[WIDTH-1]
b_msb  input  1  operand b[WIDTH-1]
sum  input  WIDTH  adder sum (combinational)
cout  input  1  adder carry out
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered carry
out_zero  output  1  out_sum == 0
out_neg  output  1  out_sum[WIDTH-1]
out_ovf  output  1  signed overflow
res_count  output  CNT_W  results accepted since reset, wraps at 2^CNT_W
ovf_count  output  CNT_W  accepted results with ovf=1, saturates at all-ones

Behaviour:
- Reset (rst=1 at clock edge): both entries invalid; out_valid=0; in_ready=1 from the following cycle; out_sum=0; all flags=0; both counters=0. Reset has priority over any simultaneous push or pop; in-flight entries are discarded.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (occupancy < 2). It is a pure function of registered occupancy, with no combinational path from out_ready.
- Flags are computed at push from the inputs and stored with the entry:
  - zero = ~|sum
  - neg = sum[WIDTH-1]
  - ovf = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb)
  - cout stored as-is; a cin of 1 is already folded into sum by the adder.
- Latency: a push at edge N gives out_valid=1 with that data after edge N (visible in cycle N+1), when the buffer was empty.
- Ordering: strict FIFO; head = oldest entry.
- Occupancy transitions:
  - 0 → 1 on push.
  - 1 → 2 on push without pop.
  - 1 → 1 on push+pop: head is replaced by the new entry in the same edge.
  - 2 → 1 on pop; push is impossible because in_ready=0.
  - 1 → 0 on pop without push.
- Hold rule: while out_valid & ~out_ready, all out_* stay stable.
- When occupancy is 0, out_* keep their last values, but out_valid=0 and they must not be consumed.
- in_valid=0 → inputs are don't-care; nothing is captured.
- res_count increments on each push.
- ovf_count increments on push with ovf=1 and holds at 2^CNT_W-1.
- Counters update in the same edge as the push.

Decomposition:
- Shared package ksa_pkg holds:
  - KSA_WIDTH = 32
  - result record type: sum, cout, zero, neg, ovf
  - function computing flags from (a_msb, b_msb, sum)
- One sub-module, ksa_skid_buf: a generic 2-entry valid/ready buffer carrying the packed result record.
- The top level does flag generation and counters only.

Test Plan:
1. Overflow: a=0x7FFFFFFF, b=0x00000001, cin=0, out_ready=1 → one cycle later out_sum=0x80000000, cout=0, neg=1, ovf=1, zero=0; ovf_count=1.
2. Carry/zero: a=0xFFFFFFFF, b=0x00000001 → out_sum=0x00000000, cout=1, zero=1, neg=0, ovf=0.
3. Negative overflow: a=0x80000000, b=0x80000000 → out_sum=0, cout=1, zero=1, ovf=1.
4. Back-pressure: out_ready=0 while pushing 3 values (1,2,3) → third is not accepted; in_ready=0 after two pushes; outputs hold 1. Then out_ready=1 → order 1,2; in_ready reasserts one cycle after the first pop.
5. Streaming: in_valid=1 and out_ready=1 continuous for 100 cycles with random operands → one result per cycle, in order; res_count=100; flags match the reference model.
6. Reset mid-operation: occupancy=2, assert rst for 1 cycle → next cycle out_valid=0, in_ready=1, res_count=0, ovf_count=0; no stale result emitted. Also check ovf_count saturation with CNT_W=2: 5 overflows → 3.
